// File: rtl/alu_pkg.sv
// Shared constants and helpers for the multi-cycle RV32I integer ALU.
package alu_pkg;

  localparam int unsigned XLEN    = 32;
  localparam int unsigned SHAMT_W = 5;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  // Operations that go through the serial shifter.
  function automatic logic is_shift_op(input logic [2:0] funct3);
    return (funct3 == F3_SLL) || (funct3 == F3_SR);
  endfunction

endpackage

// File: rtl/alu_serial_shifter.sv
// One-bit-per-cycle shifter: accumulator, remaining count and busy flag.
// A load with shamt=0 simply clears busy, which lets the top cancel a shift.
module alu_serial_shifter #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 5
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic             dir_i,      // 0 = left, 1 = right
  input  logic             arith_i,    // right shifts replicate the MSB
  input  logic [WIDTH-1:0] data_in_i,
  input  logic [CNT_W-1:0] shamt_i,
  output logic             busy_o,
  output logic [WIDTH-1:0] result_o,
  output logic             finish_o
);

  logic [WIDTH-1:0] acc_q, acc_d, shifted;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d;

  // Single-step shift of the accumulator and next-state selection.
  always_comb begin
    shifted = dir_i ? {arith_i & acc_q[WIDTH-1], acc_q[WIDTH-1:1]}
                    : {acc_q[WIDTH-2:0], 1'b0};
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    if (load_i) begin
      acc_d  = data_in_i;
      cnt_d  = shamt_i;
      busy_d = (shamt_i != '0);
    end else if (busy_q) begin
      acc_d = shifted;
      cnt_d = cnt_q - CNT_W'(1);
      if (cnt_q == CNT_W'(1)) busy_d = 1'b0;
    end
  end

  // Shifter state registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      acc_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
    end else begin
      acc_q  <= acc_d;
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
    end
  end

  assign busy_o   = busy_q;
  assign result_o = shifted;
  assign finish_o = busy_q && !load_i && (cnt_q == CNT_W'(1));

endmodule

// File: rtl/alu.sv
// Multi-cycle RV32I ALU: single-cycle logic/arith/compare, serial shifts.
// Any change of the input bundle restarts the operation.
module alu
  import alu_pkg::*;
(
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic [XLEN-1:0] aluArg1_i,
  input  logic [XLEN-1:0] aluArg2_i,
  input  logic [2:0]      funct3_i,
  input  logic            subSr_i,
  output logic [XLEN-1:0] aluRes_o,
  output logic            done_o
);

  localparam int unsigned SNAP_W = 2 * XLEN + 4;

  logic [SNAP_W-1:0]  cur_in, snap_q, snap_d;
  logic               valid_q, valid_d;
  logic [XLEN-1:0]    res_q, res_d;
  logic               done_q, done_d;
  logic               start, shift_op;
  logic [SHAMT_W-1:0] shamt;
  logic [XLEN-1:0]    op_res;
  logic               sh_busy, sh_finish;
  logic [XLEN-1:0]    sh_result;

  assign cur_in   = {aluArg1_i, aluArg2_i, funct3_i, subSr_i};
  assign start    = !valid_q || (cur_in != snap_q);
  assign shift_op = is_shift_op(funct3_i);
  assign shamt    = aluArg2_i[SHAMT_W-1:0];

  // Single-cycle result; shifts report operand A here (the shamt=0 case).
  always_comb begin
    op_res = '0;
    unique case (funct3_i)
      F3_ADD:  op_res = subSr_i ? (aluArg1_i - aluArg2_i) : (aluArg1_i + aluArg2_i);
      F3_SLT:  op_res[0] = ($signed(aluArg1_i) < $signed(aluArg2_i));
      F3_SLTU: op_res[0] = (aluArg1_i < aluArg2_i);
      F3_XOR:  op_res = aluArg1_i ^ aluArg2_i;
      F3_OR:   op_res = aluArg1_i | aluArg2_i;
      F3_AND:  op_res = aluArg1_i & aluArg2_i;
      default: op_res = aluArg1_i;
    endcase
  end

  // Non-shift ops load shamt=0 so any shift in flight is cancelled.
  alu_serial_shifter #(
    .WIDTH (XLEN),
    .CNT_W (SHAMT_W)
  ) u_shifter (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .load_i    (start),
    .dir_i     (funct3_i == F3_SR),
    .arith_i   (subSr_i),
    .data_in_i (aluArg1_i),
    .shamt_i   (shift_op ? shamt : '0),
    .busy_o    (sh_busy),
    .result_o  (sh_result),
    .finish_o  (sh_finish)
  );

  // Snapshot compare, start handling and result/done next state.
  always_comb begin
    snap_d  = snap_q;
    valid_d = valid_q;
    res_d   = res_q;
    done_d  = done_q;
    if (start) begin
      snap_d  = cur_in;
      valid_d = 1'b1;
      if (shift_op && (shamt != '0)) begin
        done_d = 1'b0;
      end else begin
        res_d  = op_res;
        done_d = 1'b1;
      end
    end else if (sh_finish) begin
      res_d  = sh_result;
      done_d = 1'b1;
    end
  end

  // Output and snapshot registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      snap_q  <= '0;
      valid_q <= 1'b0;
      res_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      snap_q  <= snap_d;
      valid_q <= valid_d;
      res_q   <= res_d;
      done_q  <= done_d;
    end
  end

  assign aluRes_o = res_q;
  assign done_o   = done_q;

endmodule

// File: tb/tb_alu.sv
// Scoreboard bench for the multi-cycle ALU.
module tb_alu;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic [31:0] aluArg1_i = '0;
  logic [31:0] aluArg2_i = '0;
  logic [2:0]  funct3_i = '0;
  logic        subSr_i = 1'b0;
  logic [31:0] aluRes_o;
  logic        done_o;

  int unsigned checks = 0;
  int unsigned failures = 0;

  typedef struct {
    logic [31:0] res;
    int unsigned lat;
    string       name;
  } exp_t;

  exp_t sb[$];

  alu dut (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .aluArg1_i (aluArg1_i),
    .aluArg2_i (aluArg2_i),
    .funct3_i  (funct3_i),
    .subSr_i   (subSr_i),
    .aluRes_o  (aluRes_o),
    .done_o    (done_o)
  );

  always #5 clk_i = ~clk_i;

  // Apply inputs just after a rising edge and record the expected outcome.
  task automatic drive(input logic [31:0] a, input logic [31:0] b, input logic [2:0] f3,
                       input logic sub, input logic [31:0] res, input int unsigned lat,
                       input string name);
    exp_t e;
    @(posedge clk_i); #1;
    aluArg1_i = a; aluArg2_i = b; funct3_i = f3; subSr_i = sub;
    e.res = res; e.lat = lat; e.name = name;
    sb.push_back(e);
  endtask

  // Count edges until done_o; note whether the held result moved meanwhile.
  task automatic wait_done(output int unsigned cyc, output bit stale);
    logic [31:0] prev;
    prev  = aluRes_o;
    stale = 1'b0;
    cyc   = 41;
    for (int unsigned i = 1; i <= 40; i++) begin
      @(posedge clk_i); #1;
      if (done_o === 1'b1) begin
        cyc = i;
        return;
      end
      if (aluRes_o !== prev) stale = 1'b1;
    end
  endtask

  task automatic test_reset();
    int unsigned c; bit s; exp_t e;
    rst_i = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk_i); #1;
      checks++;
      if (aluRes_o !== 32'h0 || done_o !== 1'b0) begin
        failures++;
        $display("FAIL reset_hold: res=%h done=%b required res=0 done=0", aluRes_o, done_o);
      end
    end
    rst_i = 1'b0;
    e.res = 32'h0; e.lat = 1; e.name = "reset_release";
    sb.push_back(e);
    wait_done(c, s);
    e = sb.pop_front();
    checks++;
    if (c !== e.lat || aluRes_o !== e.res) begin
      failures++;
      $display("FAIL %s: lat=%0d res=%h required lat=%0d res=%h", e.name, c, aluRes_o, e.lat, e.res);
    end
  endtask

  task automatic test_addsub();
    int unsigned c; bit s; exp_t e;
    logic [31:0] ta [3] = '{32'h7FFFFFFF, 32'h7FFFFFFF, 32'h0};
    logic        ts [3] = '{1'b0, 1'b1, 1'b1};
    logic [31:0] tr [3] = '{32'h80000000, 32'h7FFFFFFE, 32'hFFFFFFFF};
    for (int i = 0; i < 3; i++) begin
      drive(ta[i], 32'h1, 3'b000, ts[i], tr[i], 1, $sformatf("addsub%0d", i));
      wait_done(c, s);
      e = sb.pop_front();
      checks++;
      if (c !== e.lat) begin
        failures++;
        $display("FAIL %s_lat: got %0d required %0d", e.name, c, e.lat);
      end
      checks++;
      if (aluRes_o !== e.res) begin
        failures++;
        $display("FAIL %s_res: got %h required %h", e.name, aluRes_o, e.res);
      end
    end
  endtask

  task automatic test_cmp_logic();
    int unsigned c; bit s; exp_t e;
    logic [31:0] ta [5] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'hF0F0F0F0, 32'hF0F0F0F0, 32'hF0F0F0F0};
    logic [31:0] tb [5] = '{32'h1, 32'h1, 32'h0FF00FF0, 32'h0FF00FF0, 32'h0FF00FF0};
    logic [2:0]  tf [5] = '{3'b010, 3'b011, 3'b100, 3'b110, 3'b111};
    logic [31:0] tr [5] = '{32'h1, 32'h0, 32'hFF00FF00, 32'hFFF0FFF0, 32'h00F000F0};
    for (int i = 0; i < 5; i++) begin
      drive(ta[i], tb[i], tf[i], 1'b0, tr[i], 1, $sformatf("f3_%0d", tf[i]));
      wait_done(c, s);
      e = sb.pop_front();
      checks++;
      if (c !== e.lat || aluRes_o !== e.res) begin
        failures++;
        $display("FAIL %s: lat=%0d res=%h required lat=%0d res=%h", e.name, c, aluRes_o, e.lat, e.res);
      end
    end
  endtask

  task automatic test_shifts();
    int unsigned c; bit s; exp_t e;
    logic [31:0] tb [7] = '{32'h4, 32'h4, 32'h4, 32'h0, 32'h1F, 32'h124, 32'h4};
    logic [2:0]  tf [7] = '{3'b001, 3'b101, 3'b101, 3'b001, 3'b101, 3'b101, 3'b101};
    logic        ts [7] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    logic [31:0] tr [7] = '{32'h00000010, 32'h08000000, 32'hF8000000, 32'h80000001,
                            32'hFFFFFFFF, 32'h08000000, 32'h08000000};
    int unsigned tl [7] = '{5, 5, 5, 1, 32, 5, 5};
    for (int i = 0; i < 7; i++) begin
      drive(32'h80000001, tb[i], tf[i], ts[i], tr[i], tl[i], $sformatf("shift%0d", i));
      wait_done(c, s);
      e = sb.pop_front();
      checks++;
      if (c !== e.lat) begin
        failures++;
        $display("FAIL %s_lat: got %0d required %0d", e.name, c, e.lat);
      end
      checks++;
      if (aluRes_o !== e.res) begin
        failures++;
        $display("FAIL %s_res: got %h required %h", e.name, aluRes_o, e.res);
      end
      checks++;
      if (s) begin
        failures++;
        $display("FAIL %s_held: result changed while done=0 required held", e.name);
      end
    end
  endtask

  task automatic test_abort();
    int unsigned c; bit s; exp_t e;
    @(posedge clk_i); #1;
    aluArg1_i = 32'h1; aluArg2_i = 32'd20; funct3_i = 3'b001; subSr_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk_i); #1;
      checks++;
      if (done_o !== 1'b0) begin
        failures++;
        $display("FAIL abort_busy%0d: done=%b required 0", i, done_o);
      end
    end
    aluArg2_i = 32'd3;
    e.res = 32'h8; e.lat = 4; e.name = "abort";
    sb.push_back(e);
    wait_done(c, s);
    e = sb.pop_front();
    checks++;
    if (c !== e.lat || aluRes_o !== e.res) begin
      failures++;
      $display("FAIL %s: lat=%0d res=%h required lat=%0d res=%h", e.name, c, aluRes_o, e.lat, e.res);
    end
  endtask

  task automatic test_mid_shift_reset();
    int unsigned c; bit s; exp_t e;
    @(posedge clk_i); #1;
    aluArg1_i = 32'h1; aluArg2_i = 32'd31; funct3_i = 3'b001; subSr_i = 1'b0;
    repeat (10) @(posedge clk_i);
    #1 rst_i = 1'b1;
    @(posedge clk_i); #1;
    checks++;
    if (aluRes_o !== 32'h0 || done_o !== 1'b0) begin
      failures++;
      $display("FAIL midreset: res=%h done=%b required res=0 done=0", aluRes_o, done_o);
    end
    rst_i = 1'b0;
    e.res = 32'h80000000; e.lat = 32; e.name = "post_reset_shift";
    sb.push_back(e);
    wait_done(c, s);
    e = sb.pop_front();
    checks++;
    if (c !== e.lat || aluRes_o !== e.res) begin
      failures++;
      $display("FAIL %s: lat=%0d res=%h required lat=%0d res=%h", e.name, c, aluRes_o, e.lat, e.res);
    end
    checks++;
    if (s) begin
      failures++;
      $display("FAIL %s_stale: result changed before completion required held 0", e.name);
    end
  endtask

  task automatic test_hold();
    logic [31:0] prev;
    prev = aluRes_o;
    repeat (3) begin
      @(posedge clk_i); #1;
      checks++;
      if (done_o !== 1'b1 || aluRes_o !== 32'h80000000) begin
        failures++;
        $display("FAIL idle_hold: res=%h done=%b required res=%h done=1", aluRes_o, done_o, prev);
      end
    end
  endtask

  initial begin
    test_reset();
    test_addsub();
    test_cmp_logic();
    test_shifts();
    test_abort();
    test_mid_shift_reset();
    test_hold();
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_empty: %0d left required 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
